// File: rtl/output_capture_port.sv
// output_capture_port
// Consumer end of the processor output bus. Every word driven while
// bus_enable is high is captured into a first-word-fall-through FIFO and
// handed to a downstream reader over a valid/ready handshake. Once the
// processor halts, capture stops, the FIFO drains, and done is raised.

module output_capture_port #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [DATA_WIDTH-1:0]        bus,
    input  logic                         bus_enable,
    input  logic                         halt,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_count,
    output logic [15:0]                  write_count,
    output logic                         overflow,
    output logic                         done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic full;
    logic capture;
    logic push;
    logic pop;

    // A full FIFO still takes a word when the head leaves in the same cycle;
    // the new word lands in the slot being vacated, so ordering is kept.
    assign full    = (fill_count == CW'(DEPTH));
    assign pop     = out_valid && out_ready;
    assign capture = (state == ST_RUN) && bus_enable;
    assign push    = capture && (!full || pop);

    // Outputs come only from registered state; the head reads as zero when
    // empty so reset presents a clean bus.
    assign out_valid = (fill_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign done      = (state == ST_DONE);

    // Storage array; contents are meaningless until counted by fill_count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus;
        end
    end

    // Pointers, occupancy, capture counter and sticky overflow flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_count  <= '0;
            write_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                write_count <= write_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fill_count <= fill_count + CW'(1);
            end else if (!push && pop) begin
                fill_count <= fill_count - CW'(1);
            end
            if (capture && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Run/drain/done sequencing; a capture in the halt cycle is still taken
    // because the RUN-state push logic sees it before the state moves on.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fill_count == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_capture_port.sv
// tb_output_capture_port
// Directed bench for output_capture_port. Stimulus pushes the words it
// expects to be accepted into a scoreboard queue; an independent monitor
// compares every handshake-completed word against that queue.

module tb_output_capture_port;

    logic        clock;
    logic        resetn;
    logic [15:0] bus;
    logic        bus_enable;
    logic        halt;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fill_count;
    logic [15:0] write_count;
    logic        overflow;
    logic        done;

    int checks;
    int failures;
    logic [15:0] exp_q[$];

    output_capture_port #(
        .DATA_WIDTH(16),
        .DEPTH(8)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus),
        .bus_enable(bus_enable),
        .halt(halt),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fill_count(fill_count),
        .write_count(write_count),
        .overflow(overflow),
        .done(done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of inputs; words the bench expects to be accepted go
    // onto the scoreboard before the edge that captures them.
    task automatic applyStimulus(input logic en, input logic [15:0] val,
                                 input logic hlt, input logic rdy,
                                 input logic accepted);
        bus_enable = en;
        bus        = val;
        halt       = hlt;
        out_ready  = rdy;
        if (accepted) exp_q.push_back(val);
        tick();
    endtask

    task automatic doReset();
        resetn     = 1'b0;
        bus_enable = 1'b0;
        bus        = '0;
        halt       = 1'b0;
        out_ready  = 1'b0;
        exp_q.delete();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic drain(input string name);
        bus_enable = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) tick();
        checkOutput({name, "_empty_valid"}, 32'(out_valid), 0);
        checkOutput({name, "_scoreboard_left"}, 32'(exp_q.size()), 0);
    endtask

    // Monitor: a word is consumed when valid and ready are both high at the
    // mid-cycle sample; compare it against the oldest expected word.
    always @(negedge clock) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word: got %0d, expected none", out_data);
            end else begin
                checkOutput("stream_order", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int model_count;
        logic rdy;
        logic acc;
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        bus_enable = 1'b0;
        bus      = '0;
        halt     = 1'b0;
        out_ready = 1'b0;
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_fill_count", 32'(fill_count), 0);
        checkOutput("rst_write_count", 32'(write_count), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        doReset();

        // Test 1: streaming writes with the reader always ready, then halt.
        $display("[TB] test 1: stream 5,10,15 then halt");
        applyStimulus(1'b1, 16'd5, 1'b0, 1'b1, 1'b1);
        checkOutput("t1_head_5", 32'(out_data), 5);
        checkOutput("t1_valid_5", 32'(out_valid), 1);
        applyStimulus(1'b1, 16'd10, 1'b0, 1'b1, 1'b1);
        checkOutput("t1_head_10", 32'(out_data), 10);
        applyStimulus(1'b1, 16'd15, 1'b0, 1'b1, 1'b1);
        checkOutput("t1_head_15", 32'(out_data), 15);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_done_after_pop", 32'(done), 0);
        checkOutput("t1_fill_zero", 32'(fill_count), 0);
        tick();
        checkOutput("t1_done", 32'(done), 1);
        checkOutput("t1_write_count", 32'(write_count), 3);
        checkOutput("t1_overflow", 32'(overflow), 0);
        checkOutput("t1_scoreboard", 32'(exp_q.size()), 0);

        // Test 2: fill past capacity with no reader.
        $display("[TB] test 2: overflow on ninth word");
        doReset();
        for (int i = 1; i <= 9; i++)
            applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, (i <= 8) ? 1'b1 : 1'b0);
        checkOutput("t2_fill_count", 32'(fill_count), 8);
        checkOutput("t2_overflow", 32'(overflow), 1);
        checkOutput("t2_write_count", 32'(write_count), 8);
        drain("t2");

        // Test 3: push into a full FIFO while the head is popped.
        $display("[TB] test 3: push and pop together when full");
        doReset();
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd100, 1'b0, 1'b1, 1'b1);
        checkOutput("t3_fill_count", 32'(fill_count), 8);
        checkOutput("t3_overflow", 32'(overflow), 0);
        checkOutput("t3_write_count", 32'(write_count), 9);
        drain("t3");

        // Test 4: capture in the halt cycle, ignore afterwards.
        $display("[TB] test 4: final word in halt cycle");
        doReset();
        applyStimulus(1'b1, 16'd42, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd43, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_write_count", 32'(write_count), 1);
        checkOutput("t4_fill_count", 32'(fill_count), 1);
        checkOutput("t4_done_held", 32'(done), 0);
        checkOutput("t4_overflow", 32'(overflow), 0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_done_after_pop", 32'(done), 0);
        tick();
        checkOutput("t4_done", 32'(done), 1);
        checkOutput("t4_scoreboard", 32'(exp_q.size()), 0);

        // Test 5: twenty writes against a randomly stalling reader.
        $display("[TB] test 5: wrap-around with random ready");
        doReset();
        model_count = 0;
        for (int i = 0; i < 20; i++) begin
            rdy = 1'($urandom_range(0, 1));
            acc = (model_count < 8) || (rdy && model_count > 0);
            applyStimulus(1'b1, 16'(200 + i), 1'b0, rdy, acc);
            model_count = model_count + int'(acc) - int'(rdy && model_count > 0);
            checkOutput("t5_fill_model", 32'(fill_count), 32'(model_count));
            checks++;
            if (fill_count > 4'd8) begin
                failures++;
                $display("[TB] FAIL t5_fill_bound: got %0d, expected <= 8", fill_count);
            end
        end
        drain("t5");

        // Test 6: asynchronous reset while draining four words.
        $display("[TB] test 6: async reset in DRAIN");
        doReset();
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_fill_before", 32'(fill_count), 4);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("t6_rst_valid", 32'(out_valid), 0);
        checkOutput("t6_rst_fill", 32'(fill_count), 0);
        checkOutput("t6_rst_done", 32'(done), 0);
        tick();
        resetn = 1'b1;
        applyStimulus(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_head_7", 32'(out_data), 7);
        checkOutput("t6_valid_7", 32'(out_valid), 1);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
